// File: rtl/id_stage_if.sv
// Signal bundle around the decode stage: fetch pair in, MEM/WB feedback in,
// next-PC request and stall back to fetch, ID/EX register out to execute.
interface id_stage_if;
    logic [31:0] ID_pc;
    logic [31:0] ID_instr;
    logic        M_we;
    logic [4:0]  M_wa;
    logic        WB_we;
    logic [4:0]  WB_addr;
    logic [31:0] WB_wd;
    logic        stall;
    logic [2:0]  IF_j;
    logic [31:0] IF_pc4;
    logic [31:0] E_pc;
    logic [31:0] E_instr;
    logic [31:0] E_rd1;
    logic [31:0] E_rd2;
    logic [31:0] E_ext;
    logic [4:0]  E_wa;
    logic        E_we;
    logic        E_load;
    logic        E_store;

    modport slave (
        input  ID_pc, ID_instr, M_we, M_wa, WB_we, WB_addr, WB_wd,
        output stall, IF_j, IF_pc4, E_pc, E_instr, E_rd1, E_rd2, E_ext,
               E_wa, E_we, E_load, E_store
    );

    modport master (
        output ID_pc, ID_instr, M_we, M_wa, WB_we, WB_addr, WB_wd,
        input  stall, IF_j, IF_pc4, E_pc, E_instr, E_rd1, E_rd2, E_ext,
               E_wa, E_we, E_load, E_store
    );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: instruction decode, 32x32 GRF with write-through bypass,
// branch/jump resolution, RAW interlock against EX/MEM, and the ID/EX register.
module id_stage (
    input  logic       clk,
    input  logic       rst,
    id_stage_if.slave  bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    logic [31:0] grf_q [32];
    logic [31:0] grf_d [32];

    logic [31:0] e_pc_q, e_pc_d, e_instr_q, e_instr_d;
    logic [31:0] e_rd1_q, e_rd1_d, e_rd2_q, e_rd2_d, e_ext_q, e_ext_d;
    logic [4:0]  e_wa_q, e_wa_d;
    logic        e_we_q, e_we_d, e_load_q, e_load_d, e_store_q, e_store_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
    logic        is_beq, is_j, is_jal;
    logic        use_rs, use_rt, haz_rs, haz_rt, stall;
    logic [31:0] rd1, rd2, ext, pc4, br_tgt;
    logic [4:0]  wa;
    logic        we;
    logic [2:0]  if_j;
    logic [31:0] if_pc4;

    always_comb begin
        op      = bus.ID_instr[31:26];
        rs      = bus.ID_instr[25:21];
        rt      = bus.ID_instr[20:16];
        rd      = bus.ID_instr[15:11];
        funct   = bus.ID_instr[5:0];
        imm     = bus.ID_instr[15:0];
        is_addu = (op == OP_RTYPE) && (funct == FN_ADDU);
        is_subu = (op == OP_RTYPE) && (funct == FN_SUBU);
        is_jr   = (op == OP_RTYPE) && (funct == FN_JR);
        is_ori  = (op == OP_ORI);
        is_lui  = (op == OP_LUI);
        is_lw   = (op == OP_LW);
        is_sw   = (op == OP_SW);
        is_beq  = (op == OP_BEQ);
        is_j    = (op == OP_J);
        is_jal  = (op == OP_JAL);
        use_rs  = is_addu | is_subu | is_ori | is_lw | is_sw | is_beq | is_jr;
        use_rt  = is_addu | is_subu | is_sw | is_beq;
    end

    // GRF reads see a same-cycle WB write; $0 never bypasses.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs != 5'd0)
            rd1 = (bus.WB_we && bus.WB_addr == rs) ? bus.WB_wd : grf_q[rs];
        if (rt != 5'd0)
            rd2 = (bus.WB_we && bus.WB_addr == rt) ? bus.WB_wd : grf_q[rt];
    end

    always_comb begin
        haz_rs = use_rs && (rs != 5'd0) &&
                 ((e_we_q && e_wa_q == rs) || (bus.M_we && bus.M_wa == rs));
        haz_rt = use_rt && (rt != 5'd0) &&
                 ((e_we_q && e_wa_q == rt) || (bus.M_we && bus.M_wa == rt));
        stall  = haz_rs | haz_rt;
    end

    always_comb begin
        pc4    = bus.ID_pc + 32'd4;
        br_tgt = pc4 + {{14{imm[15]}}, imm, 2'b00};
        if_j   = 3'd0;
        if_pc4 = pc4;
        if (!stall) begin
            if (is_beq && rd1 == rd2) begin
                if_j   = 3'd1;
                if_pc4 = br_tgt;
            end else if (is_j || is_jal) begin
                if_j   = 3'd2;
                if_pc4 = {pc4[31:28], bus.ID_instr[25:0], 2'b00};
            end else if (is_jr) begin
                if_j   = 3'd3;
                if_pc4 = rd1;
            end
        end
    end

    always_comb begin
        ext = '0;
        if (is_ori)
            ext = {16'd0, imm};
        else if (is_lw || is_sw || is_beq)
            ext = {{16{imm[15]}}, imm};
        else if (is_lui)
            ext = {imm, 16'd0};
        wa = '0;
        we = 1'b0;
        if (is_addu || is_subu) begin
            wa = rd;
            we = 1'b1;
        end else if (is_ori || is_lui || is_lw) begin
            wa = rt;
            we = 1'b1;
        end else if (is_jal) begin
            wa = 5'd31;
            we = 1'b1;
        end
    end

    always_comb begin
        grf_d = grf_q;
        if (bus.WB_we && bus.WB_addr != 5'd0)
            grf_d[bus.WB_addr] = bus.WB_wd;
        e_pc_d    = '0;
        e_instr_d = '0;
        e_rd1_d   = '0;
        e_rd2_d   = '0;
        e_ext_d   = '0;
        e_wa_d    = '0;
        e_we_d    = 1'b0;
        e_load_d  = 1'b0;
        e_store_d = 1'b0;
        if (!stall) begin
            e_pc_d    = bus.ID_pc;
            e_instr_d = bus.ID_instr;
            e_rd1_d   = rd1;
            e_rd2_d   = rd2;
            e_ext_d   = ext;
            e_wa_d    = wa;
            e_we_d    = we;
            e_load_d  = is_lw;
            e_store_d = is_sw;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) grf_q[i] <= '0;
            e_pc_q    <= '0;
            e_instr_q <= '0;
            e_rd1_q   <= '0;
            e_rd2_q   <= '0;
            e_ext_q   <= '0;
            e_wa_q    <= '0;
            e_we_q    <= 1'b0;
            e_load_q  <= 1'b0;
            e_store_q <= 1'b0;
        end else begin
            grf_q     <= grf_d;
            e_pc_q    <= e_pc_d;
            e_instr_q <= e_instr_d;
            e_rd1_q   <= e_rd1_d;
            e_rd2_q   <= e_rd2_d;
            e_ext_q   <= e_ext_d;
            e_wa_q    <= e_wa_d;
            e_we_q    <= e_we_d;
            e_load_q  <= e_load_d;
            e_store_q <= e_store_d;
        end
    end

    assign bus.stall   = stall;
    assign bus.IF_j    = if_j;
    assign bus.IF_pc4  = if_pc4;
    assign bus.E_pc    = e_pc_q;
    assign bus.E_instr = e_instr_q;
    assign bus.E_rd1   = e_rd1_q;
    assign bus.E_rd2   = e_rd2_q;
    assign bus.E_ext   = e_ext_q;
    assign bus.E_wa    = e_wa_q;
    assign bus.E_we    = e_we_q;
    assign bus.E_load  = e_load_q;
    assign bus.E_store = e_store_q;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-encoded instructions with hand-computed
// decode, GRF, interlock and redirect results.
module tb_id_stage;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    id_stage_if bus ();

    id_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [31:0] instr);
        bus.ID_pc    = pc;
        bus.ID_instr = instr;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        bus.WB_we   = 1'b1;
        bus.WB_addr = a;
        bus.WB_wd   = d;
    endtask

    task automatic wb_clear();
        bus.WB_we   = 1'b0;
        bus.WB_addr = '0;
        bus.WB_wd   = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        set_id(32'h0, 32'h0);
        bus.M_we = 1'b0;
        bus.M_wa = '0;
        wb_clear();
        #12;
        chk_val("rst_e_we", {31'd0, bus.E_we}, 32'd0);
        chk_val("rst_e_pc", bus.E_pc, 32'd0);
        chk_val("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk_val("rst_if_j", {29'd0, bus.IF_j}, 32'd0);
        rst = 1'b1;
        tick();

        // ori $1,$0,0x1234
        set_id(32'h3000, 32'h3401_1234);
        #2;
        chk_val("ori_stall", {31'd0, bus.stall}, 32'd0);
        chk_val("ori_pc4", bus.IF_pc4, 32'h3004);
        tick();
        chk_val("ori_ext", bus.E_ext, 32'h0000_1234);
        chk_val("ori_wa", {27'd0, bus.E_wa}, 32'd1);
        chk_val("ori_we", {31'd0, bus.E_we}, 32'd1);
        chk_val("ori_epc", bus.E_pc, 32'h3000);

        // lui $4,0x8000
        set_id(32'h3004, 32'h3C04_8000);
        tick();
        chk_val("lui_ext", bus.E_ext, 32'h8000_0000);
        chk_val("lui_wa", {27'd0, bus.E_wa}, 32'd4);

        // addu $6,$5,$0 with same-cycle WB of $5
        set_id(32'h3008, 32'h00A0_3021);
        wb_write(5'd5, 32'hDEAD_BEEF);
        tick();
        wb_clear();
        chk_val("byp_rd1", bus.E_rd1, 32'hDEAD_BEEF);
        chk_val("byp_wa", {27'd0, bus.E_wa}, 32'd6);
        tick();
        chk_val("grf_rd1", bus.E_rd1, 32'hDEAD_BEEF);

        // asynchronous reset mid-cycle clears E_* and the GRF
        set_id(32'h300C, 32'h0);
        #2 rst = 1'b0;
        #1;
        chk_val("arst_e_we", {31'd0, bus.E_we}, 32'd0);
        chk_val("arst_e_instr", bus.E_instr, 32'd0);
        chk_val("arst_e_rd1", bus.E_rd1, 32'd0);
        rst = 1'b1;
        // addu $2,$5,$5
        set_id(32'h3010, 32'h00A5_1021);
        tick();
        chk_val("arst_grf", bus.E_rd1, 32'd0);

        set_id(32'h3014, 32'h0);
        wb_write(5'd7, 32'h55);
        tick();
        wb_write(5'd31, 32'h3008);
        tick();
        wb_clear();

        // addu $3,$1,$2 then beq $3,$7,4
        set_id(32'h301C, 32'h0022_1821);
        tick();
        set_id(32'h3020, 32'h1067_0004);
        #2;
        chk_val("ilk_c1_stall", {31'd0, bus.stall}, 32'd1);
        chk_val("ilk_c1_if_j", {29'd0, bus.IF_j}, 32'd0);
        tick();
        chk_val("ilk_c2_e_we", {31'd0, bus.E_we}, 32'd0);
        chk_val("ilk_c2_e_instr", bus.E_instr, 32'd0);
        bus.M_we = 1'b1;
        bus.M_wa = 5'd3;
        #1;
        chk_val("ilk_c2_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        bus.M_we = 1'b0;
        bus.M_wa = '0;
        wb_write(5'd3, 32'h55);
        #1;
        chk_val("ilk_c3_stall", {31'd0, bus.stall}, 32'd0);
        chk_val("ilk_c3_if_j", {29'd0, bus.IF_j}, 32'd1);
        chk_val("ilk_c3_pc4", bus.IF_pc4, 32'h3034);
        tick();
        wb_clear();
        chk_val("ilk_e_rd1", bus.E_rd1, 32'h55);
        chk_val("ilk_e_rd2", bus.E_rd2, 32'h55);
        chk_val("ilk_e_instr", bus.E_instr, 32'h1067_0004);
        chk_val("ilk_e_ext", bus.E_ext, 32'd4);

        // beq $0,$0,-3 at 0x3010
        set_id(32'h3010, 32'h1000_FFFD);
        #2;
        chk_val("beq_if_j", {29'd0, bus.IF_j}, 32'd1);
        chk_val("beq_pc4", bus.IF_pc4, 32'h3008);
        tick();
        chk_val("beq_ext", bus.E_ext, 32'hFFFF_FFFD);

        // j 0xC10 at 0x3004
        set_id(32'h3004, 32'h0800_0C10);
        #2;
        chk_val("j_if_j", {29'd0, bus.IF_j}, 32'd2);
        chk_val("j_pc4", bus.IF_pc4, 32'h0000_3040);
        tick();
        chk_val("j_e_we", {31'd0, bus.E_we}, 32'd0);

        // jal 0xC10, then jr $31 must wait one cycle for the jal in EX
        set_id(32'h3004, 32'h0C00_0C10);
        #2;
        chk_val("jal_if_j", {29'd0, bus.IF_j}, 32'd2);
        tick();
        chk_val("jal_wa", {27'd0, bus.E_wa}, 32'd31);
        chk_val("jal_we", {31'd0, bus.E_we}, 32'd1);
        set_id(32'h3100, 32'h03E0_0008);
        #2;
        chk_val("jr_stall", {31'd0, bus.stall}, 32'd1);
        chk_val("jr_stall_if_j", {29'd0, bus.IF_j}, 32'd0);
        tick();
        chk_val("jr_stall_rel", {31'd0, bus.stall}, 32'd0);
        chk_val("jr_if_j", {29'd0, bus.IF_j}, 32'd3);
        chk_val("jr_pc4", bus.IF_pc4, 32'h3008);
        tick();

        // $0 protection: addu $6,$0,$0 during and after a WB to $0
        set_id(32'h3104, 32'h0000_3021);
        wb_write(5'd0, 32'hFFFF_FFFF);
        tick();
        wb_clear();
        chk_val("r0_byp", bus.E_rd1, 32'd0);
        tick();
        chk_val("r0_grf", bus.E_rd1, 32'd0);

        // unrecognised opcode 0x3F
        set_id(32'h3200, 32'hFC00_1234);
        tick();
        chk_val("unk_we", {31'd0, bus.E_we}, 32'd0);
        chk_val("unk_instr", bus.E_instr, 32'hFC00_1234);
        chk_val("unk_pc", bus.E_pc, 32'h3200);
        chk_val("unk_wa", {27'd0, bus.E_wa}, 32'd0);
        chk_val("unk_ext", bus.E_ext, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
